// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and divisor rounding used by the timing and tx/rx blocks.
//   DEF_OVERSAMPLE : default rx ticks per bit
//   calc_div       : rounds freq/rate to the nearest integer divisor
package uart_pkg;
  localparam int DEF_OVERSAMPLE = 16;
  function automatic int calc_div(input int freq, input int rate);
    return (freq + rate / 2) / rate;
  endfunction
endpackage

// File: rtl/tick_divider.sv
// tick_divider: free-running counter that emits a one-cycle registered tick every DIV cycles.
//   clk  in  system clock
//   rst  in  synchronous reset, active-low
//   tick out high for one cycle after each DIV-th enabled edge
module tick_divider #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  logic wrap;
  assign wrap = cnt == W'(DIV - 1);
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= wrap ? '0 : cnt + W'(1);
      tick <= wrap;
    end
  end
endmodule

// File: rtl/baud_rate_clk.sv
// baud_rate_clk: UART timing generator producing baud and oversample clock-enable ticks.
//   clk    in  system clock, FREQUENCY Hz
//   rst    in  synchronous reset, active-low
//   tx_clk out one-cycle tick every TX_DIV cycles (baud rate)
//   rx_clk out one-cycle tick every RX_DIV cycles (OVERSAMPLE x baud rate)
module baud_rate_clk
  import uart_pkg::*;
#(
  parameter int BAUD_RATE  = 115200,
  parameter int FREQUENCY  = 100000000,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic clk,
  input  logic rst,
  output logic tx_clk,
  output logic rx_clk
);
  localparam int TX_DIV = calc_div(FREQUENCY, BAUD_RATE);
  localparam int RX_DIV = calc_div(FREQUENCY, OVERSAMPLE * BAUD_RATE);
  // A divisor below 2 would hold the tick permanently high.
  if (TX_DIV < 2 || RX_DIV < 2) begin : g_div_check
    $error("baud_rate_clk: TX_DIV=%0d RX_DIV=%0d, both must be >= 2", TX_DIV, RX_DIV);
  end
  tick_divider #(.DIV(TX_DIV)) u_tx (.clk(clk), .rst(rst), .tick(tx_clk));
  tick_divider #(.DIV(RX_DIV)) u_rx (.clk(clk), .rst(rst), .tick(rx_clk));
endmodule

// File: tb/tb_baud_rate_clk.sv
// tb_baud_rate_clk: checks tick timing of default and fast-divisor instances against an edge-count model.
module tb_baud_rate_clk;
  localparam int TXD = 868, RXD = 54, FTXD = 32, FRXD = 2;
  logic clk = 1'b0, rst = 1'b0;
  logic tx, rx, ftx, frx;
  logic ptx = 1'b0, prx = 1'b0, pftx = 1'b0, pfrx = 1'b0;
  int checks = 0, failures = 0, n = 0;
  int ntx, nrx, first_tx, first_rx;

  baud_rate_clk dut (.clk(clk), .rst(rst), .tx_clk(tx), .rx_clk(rx));
  baud_rate_clk #(.BAUD_RATE(100), .FREQUENCY(3200)) fast (.clk(clk), .rst(rst), .tx_clk(ftx), .rx_clk(frx));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // n counts enabled edges since the last reset edge; a tick follows every d-th such edge.
  function automatic logic [31:0] due(input int cnt, input int d);
    return (cnt > 0 && cnt % d == 0) ? 32'd1 : 32'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    n = rst ? n + 1 : 0;
    #1;
    chk("tx_clk", {31'd0, tx}, due(n, TXD));
    chk("rx_clk", {31'd0, rx}, due(n, RXD));
    chk("fast_tx_clk", {31'd0, ftx}, due(n, FTXD));
    chk("fast_rx_clk", {31'd0, frx}, due(n, FRXD));
    chk("tx_consecutive", {31'd0, ptx & tx}, 32'd0);
    chk("rx_consecutive", {31'd0, prx & rx}, 32'd0);
    chk("fast_tx_consecutive", {31'd0, pftx & ftx}, 32'd0);
    chk("fast_rx_consecutive", {31'd0, pfrx & frx}, 32'd0);
    ptx = tx; prx = rx; pftx = ftx; pfrx = frx;
  endtask

  task automatic hold_reset(input int k);
    rst = 1'b0;
    repeat (k) begin
      step();
      chk("reset_tx_low", {31'd0, tx}, 32'd0);
      chk("reset_rx_low", {31'd0, rx}, 32'd0);
    end
    rst = 1'b1;
  endtask

  initial begin
    hold_reset(5);
    ntx = 0; nrx = 0;
    for (int k = 1; k <= 5000; k++) begin
      step();
      if (tx) ntx++;
      if (rx) nrx++;
      if (k == TXD) chk("first_tx_at_868", {31'd0, tx}, 32'd1);
      if (k == RXD) chk("first_rx_at_54", {31'd0, rx}, 32'd1);
    end
    chk("tx_pulses_5000", ntx, 5);
    chk("rx_pulses_5000", nrx, 92);

    hold_reset(2);
    repeat (500) step();
    hold_reset(3);
    first_tx = -1; first_rx = -1;
    for (int k = 1; k <= 1000; k++) begin
      step();
      if (tx && first_tx < 0) first_tx = k;
      if (rx && first_rx < 0) first_rx = k;
    end
    chk("tx_after_rerelease", first_tx, TXD);
    chk("rx_after_rerelease", first_rx, RXD);

    for (int i = 0; i < 20; i++) begin
      hold_reset(int'($urandom_range(1, 4)));
      repeat ($urandom_range(1, 2500)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
